// File: rtl/frost32_byte_mem_ctrl.sv
// -----------------------------------------------------------------------------
// frost32_byte_mem_ctrl
//
// Bridges the Frost32Cpu memory port to a byte-wide, single-port synchronous
// SRAM. This block accepts one CPU request at a time: a read or a write of 8,
// 16 or 32 bits. It splits the request into big-endian single-byte SRAM
// accesses, one per cycle, starting with the most significant byte. When the
// request finishes, it raises a one-cycle done pulse. For reads, it also
// returns the assembled, zero-extended data.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   cpu_req           request strobe, only looked at while idle
//   cpu_addr          byte address of the first (most significant) byte
//   cpu_wdata         write data, right-aligned for 8/16-bit accesses
//   cpu_access_type   0 = read, 1 = write
//   cpu_access_size   0 = 8-bit, 1 = 16-bit, 2/3 = 32-bit
//   cpu_rdata         last completed read result, zero-extended
//   cpu_busy          high while a transaction is in flight
//   cpu_done          one-cycle completion pulse
//   mem_en/mem_we     SRAM access enable / write enable
//   mem_addr          SRAM byte address (wraps at 2**MEM_ADDR_WIDTH)
//   mem_wdata         SRAM write byte
//   mem_rdata         SRAM read byte, valid one cycle after a read issue
// -----------------------------------------------------------------------------
module frost32_byte_mem_ctrl #(
    parameter int unsigned MEM_ADDR_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cpu_req,
    input  logic [31:0]               cpu_addr,
    input  logic [31:0]               cpu_wdata,
    input  logic                      cpu_access_type,
    input  logic [1:0]                cpu_access_size,
    output logic [31:0]               cpu_rdata,
    output logic                      cpu_busy,
    output logic                      cpu_done,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]                mem_wdata,
    input  logic [7:0]                mem_rdata
);

    localparam int unsigned IDX_W  = 3;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Latched copy of the accepted request
    typedef struct packed {
        logic [MEM_ADDR_WIDTH-1:0] addr;
        logic [DATA_W-1:0]         wdata;
        logic                      write;
        logic [IDX_W-1:0]          nbytes;
    } req_t;

    state_t                    state_q, state_d;
    req_t                      req_q, req_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [DATA_W-1:0]         acc_q, acc_d;
    logic                      pending_q, pending_d;

    logic [DATA_W-1:0]         cpu_rdata_d;
    logic                      cpu_busy_d;
    logic                      cpu_done_d;
    logic                      mem_en_d;
    logic                      mem_we_d;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr_d;
    logic [BYTE_W-1:0]         mem_wdata_d;

    // Address bits above the SRAM range are deliberately ignored
    logic unused_addr_hi;
    assign unused_addr_hi = ^cpu_addr[31:MEM_ADDR_WIDTH];

    // Byte count for an access size; the reserved encoding behaves as 32-bit
    function automatic logic [IDX_W-1:0] size_to_nbytes(input logic [1:0] size);
        logic [IDX_W-1:0] n;
        case (size)
            2'd0:    n = IDX_W'(1);
            2'd1:    n = IDX_W'(2);
            default: n = IDX_W'(4);
        endcase
        return n;
    endfunction

    // Big-endian byte select: index 0 is the most significant byte of the
    // right-aligned nbytes-wide value
    function automatic logic [BYTE_W-1:0] pick_byte(
        input logic [DATA_W-1:0] data,
        input logic [IDX_W-1:0]  nbytes,
        input logic [IDX_W-1:0]  idx
    );
        logic [IDX_W-1:0] pos;
        pos = nbytes - idx - IDX_W'(1);
        return data[{pos[1:0], 3'b000} +: BYTE_W];
    endfunction

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        cpu_rdata_d = cpu_rdata;
        cpu_done_d  = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;

        // A read issued last cycle has its byte on mem_rdata now
        pending_d = mem_en & ~mem_we;
        if (pending_q) begin
            acc_d = {acc_q[DATA_W-BYTE_W-1:0], mem_rdata};
        end

        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    req_d.addr   = cpu_addr[MEM_ADDR_WIDTH-1:0];
                    req_d.wdata  = cpu_wdata;
                    req_d.write  = cpu_access_type;
                    req_d.nbytes = size_to_nbytes(cpu_access_size);
                    acc_d        = '0;
                    // Byte 0 is issued straight from the request inputs
                    mem_en_d     = 1'b1;
                    mem_we_d     = cpu_access_type;
                    mem_addr_d   = cpu_addr[MEM_ADDR_WIDTH-1:0];
                    if (cpu_access_type) begin
                        mem_wdata_d = pick_byte(cpu_wdata, req_d.nbytes, '0);
                    end
                    idx_d   = IDX_W'(1);
                    state_d = ACCESS;
                end
            end

            ACCESS: begin
                if (idx_q < req_q.nbytes) begin
                    mem_en_d   = 1'b1;
                    mem_we_d   = req_q.write;
                    mem_addr_d = req_q.addr + MEM_ADDR_WIDTH'(idx_q);
                    if (req_q.write) begin
                        mem_wdata_d = pick_byte(req_q.wdata, req_q.nbytes, idx_q);
                    end
                    idx_d = idx_q + IDX_W'(1);
                end else if (req_q.write) begin
                    cpu_done_d = 1'b1;
                    state_d    = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end

            DRAIN: begin
                // Final byte was captured into acc_d above
                cpu_rdata_d = acc_d;
                cpu_done_d  = 1'b1;
                state_d     = DONE;
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        cpu_busy_d = (state_d != IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            req_q     <= '0;
            idx_q     <= '0;
            acc_q     <= '0;
            pending_q <= 1'b0;
            cpu_rdata <= '0;
            cpu_busy  <= 1'b0;
            cpu_done  <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            pending_q <= pending_d;
            cpu_rdata <= cpu_rdata_d;
            cpu_busy  <= cpu_busy_d;
            cpu_done  <= cpu_done_d;
            mem_en    <= mem_en_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_frost32_byte_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_frost32_byte_mem_ctrl
//
// Self-checking bench for frost32_byte_mem_ctrl. A behavioural byte SRAM sits
// on the memory port. A reference model holds its own copy of memory as a
// plain byte array. For every request it queues two kinds of expectation:
// the byte accesses it predicts, and the completion it predicts. A negedge
// monitor compares the DUT against both queues.
// -----------------------------------------------------------------------------
module tb_frost32_byte_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_access_type;
    logic [1:0]  cpu_access_size;
    logic [31:0] cpu_rdata;
    logic        cpu_busy;
    logic        cpu_done;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    frost32_byte_mem_ctrl #(.MEM_ADDR_WIDTH(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .cpu_req         (cpu_req),
        .cpu_addr        (cpu_addr),
        .cpu_wdata       (cpu_wdata),
        .cpu_access_type (cpu_access_type),
        .cpu_access_size (cpu_access_size),
        .cpu_rdata       (cpu_rdata),
        .cpu_busy        (cpu_busy),
        .cpu_done        (cpu_done),
        .mem_en          (mem_en),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SRAM with clear and preload ports
    logic [7:0]  sram [0:65535];
    logic        clr, pl_en;
    logic [15:0] pl_addr;
    logic [7:0]  pl_data;

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 65536; i++) sram[i] <= 8'h00;
        end else if (pl_en) begin
            sram[pl_addr] <= pl_data;
        end else if (mem_en) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else        mem_rdata <= sram[mem_addr];
        end
    end

    // Reference model state
    logic [7:0]  ref_mem [0:65535];
    logic [31:0] last_rd;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [7:0]  wdata;
        int          at;
    } acc_exp_t;

    typedef struct {
        logic [31:0] rdata;
        int          at;
    } txn_exp_t;

    acc_exp_t acc_q[$];
    txn_exp_t txn_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%08h expected=0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model a request accepted at the edge that left cyc == e0
    task automatic push_txn(input logic [31:0] a, input logic [31:0] wd, input logic t,
                            input logic [1:0] s, input int e0);
        int          n;
        logic [31:0] rv;
        logic [15:0] ad;
        logic [7:0]  b;
        acc_exp_t    ae;
        txn_exp_t    te;
        n  = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
        rv = 32'h0;
        for (int i = 0; i < n; i++) begin
            ad = a[15:0] + 16'(i);
            b  = 8'h00;
            if (t) begin
                b = 8'(wd >> (8 * (n - 1 - i)));
                ref_mem[ad] = b;
            end else begin
                rv = (rv << 8) | 32'(ref_mem[ad]);
            end
            ae.addr = ad; ae.we = t; ae.wdata = b; ae.at = e0 + i;
            acc_q.push_back(ae);
        end
        if (!t) last_rd = rv;
        te.rdata = last_rd;
        te.at    = t ? e0 + n : e0 + n + 1;
        txn_q.push_back(te);
    endtask

    // Monitor: compares DUT outputs to the scoreboard, away from the active edge
    always @(negedge clk) begin
        acc_exp_t ae;
        txn_exp_t te;
        if (!rst) begin
            check("busy", 32'(cpu_busy), 32'(txn_q.size() != 0));
            if (mem_en) begin
                if (acc_q.size() == 0) begin
                    check("unexpected_mem_en", 32'(mem_en), 32'h0);
                end else begin
                    ae = acc_q.pop_front();
                    check("mem_addr", 32'(mem_addr), 32'(ae.addr));
                    check("mem_we", 32'(mem_we), 32'(ae.we));
                    check("issue_cycle", 32'(cyc), 32'(ae.at));
                    if (ae.we) check("mem_wdata", 32'(mem_wdata), 32'(ae.wdata));
                end
            end
            if (cpu_done) begin
                if (txn_q.size() == 0) begin
                    check("unexpected_done", 32'(cpu_done), 32'h0);
                end else begin
                    te = txn_q.pop_front();
                    check("cpu_rdata", cpu_rdata, te.rdata);
                    check("done_cycle", 32'(cyc), 32'(te.at));
                end
            end
        end
    end

    task automatic wait_idle();
        int w = 0;
        @(negedge clk);
        while (cpu_busy && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) check("idle_timeout", 32'(cpu_busy), 32'h0);
    endtask

    task automatic wait_drain();
        int w = 0;
        while ((txn_q.size() != 0 || acc_q.size() != 0) && w < 100) begin
            @(posedge clk);
            w++;
        end
        check("drain_timeout", 32'(w >= 100), 32'h0);
        if (w >= 100) begin
            acc_q.delete();
            txn_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic t,
                         input logic [1:0] s, output int e0);
        wait_idle();
        cpu_req = 1'b1; cpu_addr = a; cpu_wdata = wd;
        cpu_access_type = t; cpu_access_size = s;
        @(posedge clk);
        #1;
        e0 = cyc;
        push_txn(a, wd, t, s, e0);
    endtask

    task automatic do_txn(input logic [31:0] a, input logic [31:0] wd, input logic t,
                          input logic [1:0] s);
        int e0;
        issue(a, wd, t, s, e0);
        cpu_req = 1'b0;
        wait_drain();
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        ref_mem[a] = d;
        @(posedge clk);
        #1;
        pl_en = 1'b0;
    endtask

    initial begin
        int          e0;
        int          diffs;
        logic [7:0]  save2, save3;
        logic [31:0] a, wd;
        logic [15:0] lo;
        logic [7:0]  rb;

        rst = 1'b1; clr = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        cpu_req = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        cpu_access_type = 1'b0; cpu_access_size = 2'd0;
        last_rd = 32'h0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1 clr = 1'b0;

        preload(16'h0100, 8'h11);
        preload(16'h0101, 8'h22);
        preload(16'h0102, 8'h33);
        preload(16'h0103, 8'h44);
        for (int i = 0; i < 64; i++) begin
            rb = 8'($urandom());
            preload(16'h1000 + 16'(i), rb);
        end
        for (int i = 0; i < 8; i++) begin
            rb = 8'($urandom());
            preload(16'hfff8 + 16'(i), rb);
        end

        // Reset values
        @(negedge clk);
        check("rst_cpu_rdata", cpu_rdata, 32'h0);
        check("rst_cpu_busy", 32'(cpu_busy), 32'h0);
        check("rst_cpu_done", 32'(cpu_done), 32'h0);
        check("rst_mem_en", 32'(mem_en), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        @(posedge clk);
        #2 rst = 1'b0;

        // 32-bit read of preloaded bytes
        do_txn(32'h0000_0100, 32'h0, 1'b0, 2'd2);
        check("rd32_value", cpu_rdata, 32'h1122_3344);

        // 16-bit write, then 8-bit read of its low byte
        do_txn(32'h0000_0200, 32'hdead_beef, 1'b1, 2'd1);
        check("wr16_byte0", 32'(sram[16'h0200]), 32'h0000_00be);
        check("wr16_byte1", 32'(sram[16'h0201]), 32'h0000_00ef);
        check("wr_keeps_rdata", cpu_rdata, 32'h1122_3344);
        do_txn(32'h0000_0201, 32'h0, 1'b0, 2'd0);
        check("rd8_value", cpu_rdata, 32'h0000_00ef);

        // Address wrap-around with upper address bits set
        do_txn(32'h0001_fffe, 32'ha1b2_c3d4, 1'b1, 2'd2);
        check("wrap_fffe", 32'(sram[16'hfffe]), 32'h0000_00a1);
        check("wrap_ffff", 32'(sram[16'hffff]), 32'h0000_00b2);
        check("wrap_0000", 32'(sram[16'h0000]), 32'h0000_00c3);
        check("wrap_0001", 32'(sram[16'h0001]), 32'h0000_00d4);

        // Request held high: back-to-back 8-bit reads every 4 cycles
        issue(32'h0000_0100, 32'h0, 1'b0, 2'd0, e0);
        for (int k = 1; k < 5; k++) begin
            e0 = e0 + 4;
            while (cyc < e0) begin
                @(posedge clk);
                #1;
            end
            push_txn(32'h0000_0100, 32'h0, 1'b0, 2'd0, e0);
        end
        cpu_req = 1'b0;
        wait_drain();
        check("held_req_rdata", cpu_rdata, 32'h0000_0011);

        // Reserved size behaves as 32-bit
        do_txn(32'h0000_0100, 32'h0, 1'b0, 2'd3);
        check("size3_value", cpu_rdata, 32'h1122_3344);

        // Asynchronous reset during the third byte of a 32-bit write
        save2 = ref_mem[16'h0302];
        save3 = ref_mem[16'h0303];
        issue(32'h0000_0300, 32'h5566_7788, 1'b1, 2'd2, e0);
        cpu_req = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        check("pre_rst_mem_en", 32'(mem_en), 32'h1);
        rst = 1'b1;
        acc_q.delete();
        txn_q.delete();
        ref_mem[16'h0302] = save2;
        ref_mem[16'h0303] = save3;
        last_rd = 32'h0;
        #1;
        check("abort_mem_en", 32'(mem_en), 32'h0);
        check("abort_cpu_busy", 32'(cpu_busy), 32'h0);
        check("abort_cpu_done", 32'(cpu_done), 32'h0);
        check("abort_cpu_rdata", cpu_rdata, 32'h0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        check("abort_0300", 32'(sram[16'h0300]), 32'h0000_0055);
        check("abort_0301", 32'(sram[16'h0301]), 32'h0000_0066);
        check("abort_0302", 32'(sram[16'h0302]), 32'(save2));
        check("abort_0303", 32'(sram[16'h0303]), 32'(save3));
        repeat (3) @(posedge clk);

        // Randomized mix of sizes, directions and addresses
        for (int n = 0; n < 80; n++) begin
            a  = $urandom();
            wd = $urandom();
            if ($urandom_range(0, 3) == 0) lo = 16'hfffc + 16'($urandom_range(0, 3));
            else                           lo = 16'h1000 + 16'($urandom_range(0, 60));
            a[15:0] = lo;
            do_txn(a, wd, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        end

        // Whole-memory comparison against the model
        diffs = 0;
        for (int i = 0; i < 65536; i++) begin
            if (sram[i] !== ref_mem[i]) diffs++;
        end
        check("memory_image_diffs", 32'(diffs), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

endmodule
